pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the in-order RISC-V pipeline (IF,ID,EX,...,WB).

---
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: load-use stall, multi-cycle EX freeze, branch flush, forward selects.
// Optional PIPE_HAZARD_PERF_EN enables saturating stall/flush counters; otherwise both read 0.
module pipe_hazard_ctrl #(
   parameter  int DEPTH    = 3,
   parameter  int LOAD_LAT = 1,
   parameter  int MC_LAT   = 4,
   localparam int SW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [4:0]    id_rs1,
   input  logic [4:0]    id_rs2,
   input  logic          id_rs1_used,
   input  logic          id_rs2_used,
   input  logic [4:0]    id_rd,
   input  logic          id_wen,
   input  logic          id_is_load,
   input  logic          id_is_mc,
   input  logic          ex_redirect,
   output logic          pc_hold,
   output logic          ifid_hold,
   output logic          idex_bubble,
   output logic          ex_hold,
   output logic          flush_ifid,
   output logic          flush_idex,
   output logic [SW-1:0] fwd_a,
   output logic [SW-1:0] fwd_b,
   output logic [31:0]   perf_stall_cnt,
   output logic [31:0]   perf_flush_cnt
);

   logic       v_q   [1:DEPTH];
   logic       v_d   [1:DEPTH];
   logic [4:0] rd_q  [1:DEPTH];
   logic [4:0] rd_d  [1:DEPTH];
   logic       wen_q [1:DEPTH];
   logic       wen_d [1:DEPTH];
   logic       ld_q  [1:DEPTH];
   logic       ld_d  [1:DEPTH];
   logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic       u1_q, u1_d, u2_q, u2_d;
   logic [3:0] mc_cnt_q, mc_cnt_d;

   logic mc_busy, redirect, load_use, issue;

   always_comb begin
      mc_busy  = (mc_cnt_q != '0);
      redirect = ex_redirect & ~mc_busy;
      load_use = 1'b0;
      for (int unsigned s = 1; s <= unsigned'(LOAD_LAT); s++) begin
         if (v_q[s] && ld_q[s] && wen_q[s] && (rd_q[s] != '0) &&
             ((id_rs1_used && (rd_q[s] == id_rs1)) || (id_rs2_used && (rd_q[s] == id_rs2))))
            load_use = 1'b1;
      end
      load_use    = load_use & id_valid & ~mc_busy;
      issue       = id_valid & ~load_use & ~redirect & ~mc_busy;
      idex_bubble = load_use & ~redirect;
      pc_hold     = mc_busy | idex_bubble;
      ifid_hold   = pc_hold;
      ex_hold     = mc_busy;
      flush_ifid  = redirect;
      flush_idex  = redirect;
   end

   // Scan far-to-near so the nearest matching stage overrides older ones.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      for (int unsigned k = DEPTH; k >= 2; k--) begin
         if (v_q[k] && wen_q[k] && (rd_q[k] != '0) &&
             !(ld_q[k] && (k < unsigned'(2 + LOAD_LAT)))) begin
            if (u1_q && (rd_q[k] == rs1_q)) fwd_a = SW'(k);
            if (u2_q && (rd_q[k] == rs2_q)) fwd_b = SW'(k);
         end
      end
   end

   always_comb begin
      v_d      = v_q;
      rd_d     = rd_q;
      wen_d    = wen_q;
      ld_d     = ld_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      u1_d     = u1_q;
      u2_d     = u2_q;
      mc_cnt_d = mc_cnt_q;
      if (!mc_busy) begin
         for (int unsigned k = 2; k <= unsigned'(DEPTH); k++) begin
            v_d[k]   = v_q[k-1];
            rd_d[k]  = rd_q[k-1];
            wen_d[k] = wen_q[k-1];
            ld_d[k]  = ld_q[k-1];
         end
         v_d[1]   = issue;
         rd_d[1]  = id_rd;
         wen_d[1] = id_wen;
         ld_d[1]  = id_is_load;
         rs1_d    = id_rs1;
         rs2_d    = id_rs2;
         u1_d     = id_rs1_used & issue;
         u2_d     = id_rs2_used & issue;
         mc_cnt_d = (issue && id_is_mc) ? 4'(MC_LAT - 1) : '0;
      end else begin
         // EX frozen: older stages drain while a bubble enters stage 2.
         v_d[2] = 1'b0;
         for (int unsigned k = 3; k <= unsigned'(DEPTH); k++) begin
            v_d[k]   = v_q[k-1];
            rd_d[k]  = rd_q[k-1];
            wen_d[k] = wen_q[k-1];
            ld_d[k]  = ld_q[k-1];
         end
         mc_cnt_d = mc_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 1; k <= unsigned'(DEPTH); k++) begin
            v_q[k]   <= 1'b0;
            rd_q[k]  <= '0;
            wen_q[k] <= 1'b0;
            ld_q[k]  <= 1'b0;
         end
         rs1_q    <= '0;
         rs2_q    <= '0;
         u1_q     <= 1'b0;
         u2_q     <= 1'b0;
         mc_cnt_q <= '0;
      end else begin
         v_q      <= v_d;
         rd_q     <= rd_d;
         wen_q    <= wen_d;
         ld_q     <= ld_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         u1_q     <= u1_d;
         u2_q     <= u2_d;
         mc_cnt_q <= mc_cnt_d;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_hold && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush_ifid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl (DEPTH=3, LOAD_LAT=1, MC_LAT=4).
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, id_valid, id_rs1_used, id_rs2_used, id_wen, id_is_load, id_is_mc, ex_redirect;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       pc_hold, ifid_hold, idex_bubble, ex_hold, flush_ifid, flush_idex;
   logic [1:0] fwd_a, fwd_b;
   logic [31:0] perf_stall_cnt, perf_flush_cnt;

   pipe_hazard_ctrl #(.DEPTH(3), .LOAD_LAT(1), .MC_LAT(4)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wen(id_wen),
      .id_is_load(id_is_load), .id_is_mc(id_is_mc), .ex_redirect(ex_redirect),
      .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble), .ex_hold(ex_hold),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

`ifdef PIPE_HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // flags = {pc_hold, ifid_hold, idex_bubble, ex_hold, flush (both flush outputs equal)}
   localparam logic [4:0] F_NONE = 5'b00000, F_LU = 5'b11100, F_MC = 5'b11010, F_RD = 5'b00001;
   localparam logic [2:0] K_NONE = 3'b000, K_ALU = 3'b100, K_LD = 3'b110, K_MC = 3'b101;

   typedef struct {
      logic       valid;
      logic [4:0] rd, rs1, rs2;
      logic [1:0] used;
      logic [2:0] kind;
      logic       redir;
      logic [4:0] exp_flags;
      logic [1:0] exp_a, exp_b;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   int checks = 0;
   int failures = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   function automatic vec_t mk(input logic valid, input logic [4:0] rd, rs1, rs2,
                               input logic [1:0] used, input logic [2:0] kind, input logic redir,
                               input logic [4:0] ef, input logic [1:0] ea, eb);
      vec_t v;
      v.valid = valid; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.used = used;
      v.kind = kind; v.redir = redir; v.exp_flags = ef; v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   function automatic vec_t nop(input logic [1:0] ea, eb);
      return mk(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, K_NONE, 1'b0, F_NONE, ea, eb);
   endfunction

   task automatic apply(input vec_t v);
      id_valid    = v.valid;
      id_rd       = v.rd;
      id_rs1      = v.rs1;
      id_rs2      = v.rs2;
      id_rs1_used = v.used[1];
      id_rs2_used = v.used[0];
      id_wen      = v.kind[2];
      id_is_load  = v.kind[1];
      id_is_mc    = v.kind[0];
      ex_redirect = v.redir;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      if (flush_ifid !== flush_idex) return 5'bxxxxx;
      return {pc_hold, ifid_hold, idex_bubble, ex_hold, flush_ifid};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = mk(1, 5, 1, 2, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[1]  = mk(1, 6, 5, 5, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[2]  = nop(2, 2);
      tbl[3]  = mk(1, 5, 1, 2, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[4]  = nop(0, 0);
      tbl[5]  = mk(1, 7, 1, 5, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[6]  = nop(0, 3);
      tbl[7]  = mk(1, 0, 1, 2, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[8]  = mk(1, 8, 0, 0, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[9]  = nop(0, 0);
      tbl[10] = mk(1, 6, 1, 0, 2'b10, K_LD,  0, F_NONE, 0, 0);
      tbl[11] = mk(1, 7, 6, 1, 2'b11, K_ALU, 0, F_LU,   0, 0);
      tbl[12] = mk(1, 7, 6, 1, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[13] = nop(3, 0);
      tbl[14] = mk(1, 6, 1, 0, 2'b10, K_LD,  0, F_NONE, 0, 0);
      tbl[15] = mk(1, 7, 6, 1, 2'b11, K_ALU, 1, F_RD,   0, 0);
      tbl[16] = nop(0, 0);
      tbl[17] = mk(1, 9, 1, 2, 2'b11, K_MC,  0, F_NONE, 0, 0);
      tbl[18] = mk(1, 10, 9, 9, 2'b11, K_ALU, 0, F_MC,  0, 0);
      tbl[19] = mk(1, 10, 9, 9, 2'b11, K_ALU, 1, F_MC,  0, 0);
      tbl[20] = mk(1, 10, 9, 9, 2'b11, K_ALU, 0, F_MC,  0, 0);
      tbl[21] = mk(1, 10, 9, 9, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[22] = nop(2, 2);
      tbl[23] = nop(0, 0);
      tbl[24] = mk(1, 5, 1, 2, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[25] = mk(1, 5, 3, 4, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[26] = mk(1, 12, 5, 5, 2'b11, K_ALU, 0, F_NONE, 0, 0);
      tbl[27] = nop(2, 2);

      rst = 1'b1;
      apply(nop(0, 0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset outputs", {27'd0, flags(), fwd_a, fwd_b}, 32'd0);
      chk("reset stall_cnt", perf_stall_cnt, 32'd0);
      chk("reset flush_cnt", perf_flush_cnt, 32'd0);
      next_cycle();

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i]);
         @(negedge clk);
         chk($sformatf("row%0d flags", i), {27'd0, flags()}, {27'd0, tbl[i].exp_flags});
         chk($sformatf("row%0d fwd_a", i), {30'd0, fwd_a}, {30'd0, tbl[i].exp_a});
         chk($sformatf("row%0d fwd_b", i), {30'd0, fwd_b}, {30'd0, tbl[i].exp_b});
         if (tbl[i].exp_flags[4]) exp_stall++;
         if (tbl[i].exp_flags[0]) exp_flush++;
         next_cycle();
      end
      #1;
      chk("table stall_cnt", perf_stall_cnt, PERF ? 32'(exp_stall) : 32'd0);
      chk("table flush_cnt", perf_flush_cnt, PERF ? 32'(exp_flush) : 32'd0);

      // Reset pulse while a multi-cycle op is frozen in EX.
      apply(mk(1, 9, 1, 2, 2'b11, K_MC, 0, F_NONE, 0, 0));
      @(negedge clk);
      chk("mc issue pc_hold", {31'd0, pc_hold}, 32'd0);
      next_cycle();
      apply(mk(1, 10, 9, 9, 2'b11, K_ALU, 0, F_MC, 0, 0));
      @(negedge clk);
      chk("mc hold1 flags", {27'd0, flags()}, {27'd0, F_MC});
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("mc hold2 flags", {27'd0, flags()}, {27'd0, F_MC});
      next_cycle();
      rst = 1'b0;
      apply(nop(0, 0));
      @(negedge clk);
      chk("post-rst outputs", {27'd0, flags(), fwd_a, fwd_b}, 32'd0);
      chk("post-rst stall_cnt", perf_stall_cnt, 32'd0);
      chk("post-rst flush_cnt", perf_flush_cnt, 32'd0);
      next_cycle();
      apply(mk(1, 6, 1, 0, 2'b10, K_LD, 0, F_NONE, 0, 0));
      @(negedge clk);
      chk("post-rst lw flags", {27'd0, flags()}, 32'd0);
      next_cycle();
      apply(mk(1, 7, 6, 1, 2'b11, K_ALU, 0, F_LU, 0, 0));
      @(negedge clk);
      chk("post-rst load-use flags", {27'd0, flags()}, {27'd0, F_LU});
      next_cycle();
      @(negedge clk);
      chk("post-rst issue flags", {27'd0, flags()}, 32'd0);
      chk("post-rst count stall", perf_stall_cnt, PERF ? 32'd1 : 32'd0);
      chk("post-rst count flush", perf_flush_cnt, 32'd0);
      next_cycle();
      apply(nop(0, 0));
      @(negedge clk);
      chk("post-rst fwd_a", {30'd0, fwd_a}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
